// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the instruction-fetch
//   (IF) and data-access (MEM) stages. One transaction is in flight at a time:
//   IDLE picks a winner (data beats fetch), WAIT counts down the memory latency
//   and then returns the read data to the owner. A pipeline flush squashes an
//   outstanding fetch so that its data never reaches the fetch stage.
//   Optional feature macro: ARB_STARVE_GUARD_EN. When it is defined, a starvation
//   counter forces a fetch grant after STARVE_MAX data grants have bypassed a
//   waiting fetch. When it is undefined, data has strict priority.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // The latency and starvation counters are 4 bits wide, so both limits must fit in 1..15
  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must lie within 1..15");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [3:0]    r_lat_cnt;
  logic          r_owner_if;
  logic          r_is_store;
  logic          r_squash;

  logic          r_if_gnt;
  logic          r_d_gnt;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_if_rvalid;
  logic          r_d_rvalid;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_busy;

  logic          w_idle;
  logic          w_wait;
  logic          w_last;
  logic          w_if_elig;
  logic          w_force_if;
  logic          w_grant_d;
  logic          w_grant_if;
  logic          w_issue;
  logic          w_mem_we_nxt;
  logic [AW-1:0] w_mem_addr_nxt;
  logic [DW-1:0] w_mem_wdata_nxt;
  logic          w_if_rvalid_nxt;
  logic          w_d_rvalid_nxt;
  logic          w_busy_nxt;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_wait    = (r_state == ST_WAIT);
  // Final latency cycle: memory data is on mem_rdata and is captured at this edge
  assign w_last    = w_wait && (r_lat_cnt == 4'd1);
  // A flush in the decision cycle makes the fetch ineligible for that cycle only
  assign w_if_elig = if_req && !flush;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] r_starve_cnt;

  assign w_force_if = w_if_elig && (r_starve_cnt == STARVE_LIM);

  // Count data grants that bypassed an eligible fetch; clear once IF is served or stops asking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_if) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_d && w_if_elig && (r_starve_cnt != 4'hF)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end else if (w_idle && !if_req) begin
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // Data holds the older instruction, so it wins unless the starvation guard forces IF
  assign w_grant_d  = w_idle && d_req && !w_force_if;
  assign w_grant_if = w_idle && w_if_elig && !w_grant_d;
  assign w_issue    = w_grant_d || w_grant_if;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: issue moves to WAIT, the last latency cycle returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of the registered memory-side and response strobes
  always_comb begin
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = 1'b0;
    if (w_grant_d) begin
      w_mem_addr_nxt  = d_addr;
      w_mem_wdata_nxt = d_we ? d_wdata : {DW{1'b0}};
      w_mem_we_nxt    = d_we;
    end else if (w_grant_if) begin
      w_mem_addr_nxt  = if_addr;
      w_mem_wdata_nxt = {DW{1'b0}};
      w_mem_we_nxt    = 1'b0;
    end else begin
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_we_nxt    = 1'b0;
    end
    // A flush seen during the final latency cycle squashes the fetch as well
    w_if_rvalid_nxt = w_last && r_owner_if && !(r_squash || flush);
    w_d_rvalid_nxt  = w_last && !r_owner_if;
    w_busy_nxt      = w_issue || w_wait;
  end

  // Registered outputs: grant/issue pulses, memory command, response pulses, busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_if_gnt    <= w_grant_if;
      r_d_gnt     <= w_grant_d;
      r_mem_en    <= w_issue;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_rvalid <= w_if_rvalid_nxt;
      r_d_rvalid  <= w_d_rvalid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Transaction bookkeeping: latency countdown, owner, store flag and fetch squash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt  <= 4'd0;
      r_owner_if <= 1'b0;
      r_is_store <= 1'b0;
      r_squash   <= 1'b0;
    end else if (w_issue) begin
      r_lat_cnt  <= LAT_INIT;
      r_owner_if <= w_grant_if;
      r_is_store <= w_grant_d && d_we;
      r_squash   <= 1'b0;
    end else if (w_wait) begin
      r_lat_cnt  <= r_lat_cnt - 4'd1;
      r_owner_if <= r_owner_if;
      r_is_store <= r_is_store;
      r_squash   <= r_squash || (r_owner_if && flush);
    end else begin
      r_lat_cnt  <= r_lat_cnt;
      r_owner_if <= r_owner_if;
      r_is_store <= r_is_store;
      r_squash   <= r_squash;
    end
  end

  // Read-data capture; squashed fetches leave if_rdata untouched, stores return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= {DW{1'b0}};
      r_d_rdata  <= {DW{1'b0}};
    end else begin
      if (w_if_rvalid_nxt) begin
        r_if_rdata <= mem_rdata;
      end else begin
        r_if_rdata <= r_if_rdata;
      end
      if (w_d_rvalid_nxt) begin
        r_d_rdata <= r_is_store ? {DW{1'b0}} : mem_rdata;
      end else begin
        r_d_rdata <= r_d_rdata;
      end
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  // A flush arriving in the response cycle itself still cancels the fetch return
  assign if_rvalid = r_if_rvalid && !flush;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4). Expected
//   responses are queued when requests are driven and compared by a monitor
//   as the DUT returns them; grant timing and memory-side fields are checked
//   inline in the stimulus sequence.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(
    .AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } exp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cycle = 0;
  int          last_gnt_cyc = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit is_if, input logic [31:0] data);
    exp_t e;
    e.is_if = is_if;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Single-port memory: access on the edge that sees mem_en, data valid the following cycle
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        mem_rdata <= 32'hBAD0_0000 ^ mem_addr;
      end else begin
        mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0000_0000;
      end
    end
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Response monitor: every rvalid must match the oldest queued expectation, 2 cycles after its grant
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_gnt || d_gnt) last_gnt_cyc = cycle;
      if (if_rvalid || d_rvalid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rvalid_port", {62'd0, if_rvalid, d_rvalid}, mon_e.is_if ? 64'd2 : 64'd1);
          chk("rdata", {32'd0, (mon_e.is_if ? if_rdata : d_rdata)}, {32'd0, mon_e.data});
          chk("rvalid_latency", 64'(cycle - last_gnt_cyc), 64'd2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit exp_if;
    rst_n = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdata = 32'h0;
    mem[32'h0000_0040] = 32'h8C01_0004;
    mem[32'h0000_0044] = 32'h3333_4444;
    mem[32'h0000_0048] = 32'h5555_6666;
    mem[32'h0000_0100] = 32'h1111_2222;

    // Reset state
    cyc(); cyc(); cyc();
    chk("rst_ctrl", {57'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}, 64'd0);
    chk("rst_mem", {mem_addr, mem_wdata}, 64'd0);
    chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // Lone fetch
    if_addr = 32'h40; if_req = 1'b1; push_exp(1'b1, 32'h8C01_0004);
    cyc();
    chk("t2_gnt", {61'd0, if_gnt, d_gnt, mem_en}, 64'b101);
    chk("t2_mem_addr", {32'd0, mem_addr}, 64'h40);
    chk("t2_mem_we", {63'd0, mem_we}, 64'd0);
    chk("t2_busy_t", {63'd0, busy}, 64'd1);
    cyc();
    chk("t2_busy_t1", {62'd0, busy, mem_en}, 64'b10);
    cyc();
    chk("t2_rvalid", {62'd0, if_rvalid, busy}, 64'b11);
    chk("t2_if_rdata", {32'd0, if_rdata}, 64'h8C01_0004);
    if_req = 1'b0;
    cyc();
    chk("t2_idle", {62'd0, busy, if_rvalid}, 64'd0);

    // Fetch and load together: data first, fetch right after the load returns
    d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1; if_addr = 32'h44; if_req = 1'b1;
    push_exp(1'b0, 32'h1111_2222); push_exp(1'b1, 32'h3333_4444);
    cyc();
    chk("t3_dgnt", {62'd0, if_gnt, d_gnt}, 64'b01);
    chk("t3_mem_addr", {32'd0, mem_addr}, 64'h100);
    cyc(); cyc();
    chk("t3_drvalid", {63'd0, d_rvalid}, 64'd1);
    d_req = 1'b0;
    cyc();
    chk("t3_ifgnt", {62'd0, if_gnt, d_gnt}, 64'b10);
    chk("t3_if_addr", {32'd0, mem_addr}, 64'h44);
    cyc(); cyc();
    chk("t3_ifrvalid", {63'd0, if_rvalid}, 64'd1);
    if_req = 1'b0;
    cyc();

    // Store, then load it back
    d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_req = 1'b1; push_exp(1'b0, 32'h0);
    cyc();
    chk("t4_issue", {61'd0, d_gnt, mem_en, mem_we}, 64'b111);
    chk("t4_mem", {mem_addr, mem_wdata}, {32'h200, 32'hDEAD_BEEF});
    cyc(); cyc();
    chk("t4_ack", {31'd0, d_rvalid, d_rdata}, {31'd0, 1'b1, 32'h0});
    d_req = 1'b0; d_we = 1'b0;
    cyc();
    d_req = 1'b1; push_exp(1'b0, 32'hDEAD_BEEF);
    cyc();
    chk("t4_rd_issue", {62'd0, d_gnt, mem_we}, 64'b10);
    cyc(); cyc();
    chk("t4_rd_data", {32'd0, d_rdata}, 64'hDEAD_BEEF);
    d_req = 1'b0;
    cyc();

    // Flush in IDLE blocks the fetch for one cycle only
    if_addr = 32'h44; if_req = 1'b1; flush = 1'b1; push_exp(1'b1, 32'h3333_4444);
    cyc();
    chk("fi_blocked", {62'd0, if_gnt, mem_en}, 64'd0);
    flush = 1'b0;
    cyc();
    chk("fi_granted", {63'd0, if_gnt}, 64'd1);
    cyc(); cyc();
    if_req = 1'b0;
    cyc();

    // Data, fetch and flush together: data granted, fetch later unharmed
    d_addr = 32'h100; d_req = 1'b1; if_req = 1'b1; flush = 1'b1;
    push_exp(1'b0, 32'h1111_2222); push_exp(1'b1, 32'h3333_4444);
    cyc();
    chk("df_dgnt", {62'd0, if_gnt, d_gnt}, 64'b01);
    flush = 1'b0;
    cyc(); cyc();
    d_req = 1'b0;
    cyc();
    chk("df_ifgnt", {63'd0, if_gnt}, 64'd1);
    cyc(); cyc();
    chk("df_ifrvalid", {63'd0, if_rvalid}, 64'd1);
    if_req = 1'b0;
    cyc();

    // Fetch squashed by flush one cycle after its grant
    if_addr = 32'h48; if_req = 1'b1;
    cyc();
    chk("t5_gnt", {63'd0, if_gnt}, 64'd1);
    cyc();
    flush = 1'b1; if_req = 1'b0;
    cyc();
    flush = 1'b0;
    chk("t5_no_rvalid", {62'd0, if_rvalid, busy}, 64'b01);
    chk("t5_rdata_kept", {32'd0, if_rdata}, 64'h3333_4444);
    cyc();
    chk("t5_idle", {63'd0, busy}, 64'd0);
    if_addr = 32'h40; if_req = 1'b1; push_exp(1'b1, 32'h8C01_0004);
    cyc();
    chk("t5_regnt", {63'd0, if_gnt}, 64'd1);
    cyc(); cyc();
    chk("t5_refetch", {31'd0, if_rvalid, if_rdata}, {31'd0, 1'b1, 32'h8C01_0004});
    if_req = 1'b0;
    cyc();

    // Reset in the middle of a load: outputs clear at once, nothing returns later
    d_addr = 32'h100; d_req = 1'b1;
    cyc();
    chk("t1_gnt", {63'd0, d_gnt}, 64'd1);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_ctrl", {57'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}, 64'd0);
    chk("t1_mem", {mem_addr, mem_wdata}, 64'd0);
    chk("t1_rdata", {if_rdata, d_rdata}, 64'd0);
    d_req = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk("t1_quiet", {61'd0, d_rvalid, busy, mem_en}, 64'd0);

    // Data and fetch held for ten accesses
    d_addr = 32'h100; d_we = 1'b0; if_addr = 32'h44;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_if = (k == 4) || (k == 9);
`else
      exp_if = 1'b0;
`endif
      push_exp(exp_if, exp_if ? 32'h3333_4444 : 32'h1111_2222);
    end
    d_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_if = (k == 4) || (k == 9);
`else
      exp_if = 1'b0;
`endif
      got = 1'b0;
      for (int w = 0; w < 6; w++) begin
        cyc();
        if (if_gnt || d_gnt) begin
          got = 1'b1;
          break;
        end
      end
      chk($sformatf("t6_gnt%0d_seen", k), {63'd0, got}, 64'd1);
      chk($sformatf("t6_gnt%0d_who", k), {62'd0, if_gnt, d_gnt}, exp_if ? 64'b10 : 64'b01);
      cyc(); cyc();
      if (k == 9) begin
        d_req = 1'b0; if_req = 1'b0;
      end
    end
    cyc(); cyc();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
